// File: rtl/t05_ssdisp_pkg.sv
// ---------------------------------------------------------------------------
// t05_ssdisp_pkg
// Shared definitions for the multiplexed seven-segment display driver.
//   state_t    : scan FSM states (idle, blank guard, digit shown)
//   SEG_BLANK  : segment pattern with every segment off
//   HEX_SEG    : nibble -> segment table, bit 6 = a ... bit 0 = g
// ---------------------------------------------------------------------------
package t05_ssdisp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index is the nibble value; lowercase glyphs are used for b and d so
    // they cannot be confused with 8 and 0.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h73, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/t05_ssdec_hex.sv
// ---------------------------------------------------------------------------
// t05_ssdec_hex
// Combinational hex-to-seven-segment decoder with a blanking override.
//   nibble : 4-bit hex digit to decode
//   blank  : 1 forces every segment off
//   seg    : active-high segments, seg[6]=a ... seg[0]=g
// ---------------------------------------------------------------------------
module t05_ssdec_hex
    import t05_ssdisp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup, with blanking taking priority over the decoded glyph.
    always_comb begin
        seg = HEX_SEG[nibble];
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/t05_ssdisp_scan.sv
// ---------------------------------------------------------------------------
// t05_ssdisp_scan
// Time-multiplexed seven-segment display driver for NUM_DIGITS hex digits.
// Each digit slot is CLK_DIV cycles long: GUARD cycles with every digit
// deselected (anti-ghosting) followed by the decoded digit.
//   clk, rst     : clock, asynchronous active-high reset
//   value        : hex digits, nibble 0 is the rightmost digit
//   load         : capture value / dp_in / blink_mask into the display register
//   enable       : scan enable, low blanks the display
//   lz_suppress  : blank leading zero digits (digit 0 always shown)
//   dp_in        : decimal point per digit
//   blink_mask   : digits that blink
//   seg_out      : segments a..g (bit 6 = a), polarity per SEG_ACTIVE_LOW
//   dp_out       : decimal point of the selected digit, polarity per SEG_ACTIVE_LOW
//   dig_sel      : one-hot digit select, polarity per DIG_ACTIVE_LOW
//   frame_done   : high during the final cycle of the last digit slot
// ---------------------------------------------------------------------------
module t05_ssdisp_scan
    import t05_ssdisp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int GUARD          = 16,
    parameter int BLINK_DIV      = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    lz_suppress,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W    = $clog2(CLK_DIV);
    localparam int BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SHOW_LEN = CLK_DIV - GUARD;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(SHOW_LEN - 1);
    localparam logic [BLK_W-1:0] BLINK_END = BLK_W'(BLINK_DIV - 1);

    // Pin-level "off" patterns; XOR-ing an active-high value with these
    // applies the configured polarity.
    localparam logic [6:0]            SEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF_PIN  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_PIN = (DIG_ACTIVE_LOW != 0) ?
                                                    {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_vis_q, blink_vis_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dp_reg_q, dp_reg_d;
    logic [NUM_DIGITS-1:0]   bmask_q, bmask_d;
    logic [6:0]              glyph_q, glyph_d;
    logic                    gdp_q, gdp_d;
    logic [6:0]              seg_pin_q, seg_pin_d;
    logic                    dp_pin_q, dp_pin_d;
    logic [NUM_DIGITS-1:0]   dig_pin_q, dig_pin_d;
    logic                    frame_done_q, frame_done_d;

    logic                    latch_glyph;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0][3:0] nibbles;
    logic [3:0]              sel_nibble;
    logic                    blink_hide;
    logic                    dec_blank;
    logic [6:0]              dec_seg;

    // Leading-zero map: walk from the most significant digit down and keep
    // blanking while every digit seen so far is zero. Digit 0 never blanks.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run & (val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run & (i != 0);
        end
    end

    // Glyph for the digit about to be shown, evaluated against the index and
    // blink phase that take effect on the coming edge.
    always_comb begin
        nibbles    = val_q;
        sel_nibble = nibbles[idx_d];
        blink_hide = ~blink_vis_d & bmask_q[idx_d];
        dec_blank  = (lz_suppress & lz_mask[idx_d]) | blink_hide;
    end

    t05_ssdec_hex u_dec (
        .nibble (sel_nibble),
        .blank  (dec_blank),
        .seg    (dec_seg)
    );

    // Next-state logic: display register capture, blink phase, scan FSM and
    // the registered pin values. The glyph is frozen at guard entry so a load
    // never changes a digit halfway through its slot.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        val_d       = val_q;
        dp_reg_d    = dp_reg_q;
        bmask_d     = bmask_q;
        glyph_d     = glyph_q;
        gdp_d       = gdp_q;
        latch_glyph = 1'b0;

        if (frame_done_q) begin
            if (blink_cnt_q == BLINK_END) begin
                blink_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (load) begin
            val_d    = value;
            dp_reg_d = dp_in;
            bmask_d  = blink_mask;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_GUARD;
                    idx_d       = '0;
                    cnt_d       = '0;
                    latch_glyph = 1'b1;
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_END) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_END) begin
                        state_d     = ST_GUARD;
                        cnt_d       = '0;
                        idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        latch_glyph = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        if (latch_glyph) begin
            glyph_d = dec_seg;
            gdp_d   = dp_reg_q[idx_d] & ~blink_hide;
        end

        seg_pin_d    = SEG_OFF_PIN;
        dp_pin_d     = DP_OFF_PIN;
        dig_pin_d    = DIG_OFF_PIN;
        frame_done_d = 1'b0;
        if (state_d == ST_SHOW) begin
            seg_pin_d    = glyph_q ^ SEG_OFF_PIN;
            dp_pin_d     = gdp_q ^ DP_OFF_PIN;
            dig_pin_d    = (NUM_DIGITS'(1) << idx_d) ^ DIG_OFF_PIN;
            frame_done_d = (idx_d == LAST_IDX) && (cnt_d == SHOW_END);
        end
    end

    // Single state register for the whole driver; reset drives the pins to
    // their inactive level immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            blink_cnt_q  <= '0;
            blink_vis_q  <= 1'b1;
            val_q        <= '0;
            dp_reg_q     <= '0;
            bmask_q      <= '0;
            glyph_q      <= SEG_BLANK;
            gdp_q        <= 1'b0;
            seg_pin_q    <= SEG_OFF_PIN;
            dp_pin_q     <= DP_OFF_PIN;
            dig_pin_q    <= DIG_OFF_PIN;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_vis_q  <= blink_vis_d;
            val_q        <= val_d;
            dp_reg_q     <= dp_reg_d;
            bmask_q      <= bmask_d;
            glyph_q      <= glyph_d;
            gdp_q        <= gdp_d;
            seg_pin_q    <= seg_pin_d;
            dp_pin_q     <= dp_pin_d;
            dig_pin_q    <= dig_pin_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_pin_q;
    assign dp_out     = dp_pin_q;
    assign dig_sel    = dig_pin_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_t05_ssdisp_scan.sv
// ---------------------------------------------------------------------------
// tb_t05_ssdisp_scan
// Directed bench for t05_ssdisp_scan with 4 digits, 8-cycle slots, 2-cycle
// guard and a 2-frame blink half-period. A second instance with active-low
// pins shares all inputs and is checked around reset.
// ---------------------------------------------------------------------------
module tb_t05_ssdisp_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic        lz_suppress;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;

    logic [6:0]  seg_out, seg_out_al;
    logic        dp_out, dp_out_al;
    logic [3:0]  dig_sel, dig_sel_al;
    logic        frame_done, frame_done_al;

    int tests_run    = 0;
    int tests_failed = 0;
    int frame_count  = 0;

    always #5 clk = ~clk;

    t05_ssdisp_scan #(
        .NUM_DIGITS(4), .CLK_DIV(8), .GUARD(2), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable),
        .lz_suppress(lz_suppress), .dp_in(dp_in), .blink_mask(blink_mask),
        .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    t05_ssdisp_scan #(
        .NUM_DIGITS(4), .CLK_DIV(8), .GUARD(2), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable),
        .lz_suppress(lz_suppress), .dp_in(dp_in), .blink_mask(blink_mask),
        .seg_out(seg_out_al), .dp_out(dp_out_al), .dig_sel(dig_sel_al), .frame_done(frame_done_al)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Blink phase for the current frame: two visible frames, two hidden.
    function automatic logic blinkVisible();
        return ((frame_count / 2) % 2) == 0;
    endfunction

    // Stop scanning, capture new display contents, then re-enable so the
    // next edge enters the guard of digit 0.
    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp,
                                 input logic [3:0] mask, input logic lz);
        enable      = 1'b0;
        value       = v;
        dp_in       = dp;
        blink_mask  = mask;
        lz_suppress = lz;
        load        = 1'b1;
        tick();
        checkOutput("idle_dig", 32'(dig_sel), 32'h0);
        load   = 1'b0;
        enable = 1'b1;
    endtask

    // One 8-cycle slot: two guard cycles, then six cycles of the glyph.
    // Optionally loads a new value partway through the shown portion.
    task automatic checkSlot(input string tag, input int idx, input logic [6:0] exp_seg,
                             input logic exp_dp, input logic do_load, input logic [15:0] load_val);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        tick();
        checkOutput($sformatf("%s_guard_dig", tag), 32'(dig_sel), 32'h0);
        checkOutput($sformatf("%s_guard_seg", tag), 32'(seg_out), 32'h0);
        tick();
        checkOutput($sformatf("%s_guard2_dig", tag), 32'(dig_sel), 32'h0);
        tick();
        checkOutput($sformatf("%s_show_dig", tag), 32'(dig_sel), 32'(one_hot));
        checkOutput($sformatf("%s_show_seg", tag), 32'(seg_out), 32'(exp_seg));
        checkOutput($sformatf("%s_show_dp", tag), 32'(dp_out), 32'(exp_dp));
        checkOutput($sformatf("%s_show_fd", tag), 32'(frame_done), 32'h0);
        if (do_load) begin
            value = load_val;
            load  = 1'b1;
            tick();
            load = 1'b0;
            repeat (3) tick();
        end else begin
            repeat (4) tick();
        end
        tick();
        checkOutput($sformatf("%s_end_dig", tag), 32'(dig_sel), 32'(one_hot));
        checkOutput($sformatf("%s_end_seg", tag), 32'(seg_out), 32'(exp_seg));
        checkOutput($sformatf("%s_end_fd", tag), 32'(frame_done), 32'(idx == 3));
        if (idx == 3) begin
            frame_count++;
        end
    endtask

    // Full frame; segs packs {digit3, digit2, digit1, digit0} glyphs.
    task automatic checkFrame(input string tag, input logic [27:0] segs,
                              input logic [3:0] dps, input logic [3:0] mask);
        logic       hide;
        logic [6:0] s;
        for (int i = 0; i < 4; i++) begin
            hide = mask[i] && !blinkVisible();
            s    = hide ? 7'h00 : segs[7*i +: 7];
            checkSlot($sformatf("%s_d%0d", tag, i), i, s, dps[i] && !hide, 1'b0, 16'h0);
        end
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        rst         = 1'b0;
        value       = 16'h0;
        load        = 1'b0;
        enable      = 1'b0;
        lz_suppress = 1'b0;
        dp_in       = 4'h0;
        blink_mask  = 4'h0;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_seg", 32'(seg_out), 32'h00);
        checkOutput("rst_dig", 32'(dig_sel), 32'h0);
        checkOutput("rst_dp", 32'(dp_out), 32'h0);
        checkOutput("rst_fd", 32'(frame_done), 32'h0);
        checkOutput("rst_al_seg", 32'(seg_out_al), 32'h7F);
        checkOutput("rst_al_dig", 32'(dig_sel_al), 32'hF);
        checkOutput("rst_al_dp", 32'(dp_out_al), 32'h1);
        tick();
        rst = 1'b0;
        tick();

        // Basic scan order and decimal point on digit 1.
        applyStimulus(16'h1234, 4'b0010, 4'b0000, 1'b0);
        checkFrame("hex1234a", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0010, 4'b0000);
        checkFrame("hex1234b", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0010, 4'b0000);

        // Leading-zero suppression.
        applyStimulus(16'h0070, 4'b0000, 4'b0000, 1'b1);
        checkFrame("lz0070", {7'h00, 7'h00, 7'h70, 7'h7E}, 4'b0000, 4'b0000);
        applyStimulus(16'h0000, 4'b0100, 4'b0000, 1'b1);
        checkFrame("lzzero", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0100, 4'b0000);

        // Blink on digit 0 across both phases.
        applyStimulus(16'hABCD, 4'b0000, 4'b0001, 1'b0);
        for (int f = 0; f < 4; f++) begin
            checkFrame($sformatf("blink%0d", f), {7'h77, 7'h1F, 7'h4E, 7'h3D}, 4'b0000, 4'b0001);
        end

        // Load during digit 1's slot: digit 1 keeps its glyph, later slots
        // pick up 0x0005.
        checkSlot("midload_d0", 0, blinkVisible() ? 7'h3D : 7'h00, 1'b0, 1'b0, 16'h0);
        checkSlot("midload_d1", 1, 7'h4E, 1'b0, 1'b1, 16'h0005);
        checkSlot("midload_d2", 2, 7'h7E, 1'b0, 1'b0, 16'h0);
        checkSlot("midload_d3", 3, 7'h7E, 1'b0, 1'b0, 16'h0);
        checkFrame("afterload", {7'h7E, 7'h7E, 7'h7E, 7'h5B}, 4'b0000, 4'b0001);

        // Drop enable in the middle of digit 0's shown portion.
        tick();
        tick();
        tick();
        checkOutput("drop_show_dig", 32'(dig_sel), 32'h1);
        tick();
        tick();
        enable = 1'b0;
        tick();
        checkOutput("drop_dig", 32'(dig_sel), 32'h0);
        checkOutput("drop_seg", 32'(seg_out), 32'h00);
        checkOutput("drop_dp", 32'(dp_out), 32'h0);
        tick();
        checkOutput("drop_hold_dig", 32'(dig_sel), 32'h0);
        enable = 1'b1;
        checkFrame("restart", {7'h7E, 7'h7E, 7'h7E, 7'h5B}, 4'b0000, 4'b0001);

        // Reset in the middle of a frame, checked asynchronously.
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_seg", 32'(seg_out), 32'h00);
        checkOutput("midrst_dig", 32'(dig_sel), 32'h0);
        checkOutput("midrst_al_seg", 32'(seg_out_al), 32'h7F);
        checkOutput("midrst_al_dig", 32'(dig_sel_al), 32'hF);
        checkOutput("midrst_al_dp", 32'(dp_out_al), 32'h1);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        frame_count = 0;
        tick();
        enable = 1'b1;
        checkFrame("postreset", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/t05_ssdisp_scan.md
Name: t05_ssdisp_scan

Overview:
- Parametrised multiplexed seven-segment display driver; successor to the team's single-digit hex decoder.
- Holds NUM_DIGITS hex nibbles and time-multiplexes them onto one shared segment bus with per-digit select.
- Adds anti-ghosting blank guard, leading-zero suppression, per-digit blink, decimal points, and output polarity options.
- Sits between datapath/score logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; 1..8.
- CLK_DIV, 1000: clock cycles per digit slot; must exceed GUARD.
- GUARD, 16: cycles at the start of each slot with all digits deselected; >= 1.
- BLINK_DIV, 64: full frames per blink half-period; >= 1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out and dp_out at the pins.
- DIG_ACTIVE_LOW, 0: 1 inverts dig_sel at the pins.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- value  in  4*NUM_DIGITS  hex digits; nibble 0 (LSBs) is the rightmost digit
- load  in  1  capture value, dp_in and blink_mask into the display register
- enable  in  1  scan enable; low blanks the display
- lz_suppress  in  1  blank leading zero digits
- dp_in  in  NUM_DIGITS  decimal point per digit
- blink_mask  in  NUM_DIGITS  digits that blink
- seg_out  out  7  segments; seg_out[6]=a through seg_out[0]=g
- dp_out  out  1  decimal point of the selected digit
- dig_sel  out  NUM_DIGITS  one-hot digit select
- frame_done  out  1  one-cycle pulse at the end of the last digit slot

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk.
- Reset state: display register 0, digit index 0, slot counter 0, blink counter 0, blink phase visible, state IDLE.
- During reset, all outputs are at their inactive level after polarity: seg 0, dp 0, dig_sel 0, frame_done 0.
- All outputs are registered.
- FSM states:
  - IDLE: outputs blank. When enable=1, go to GUARD with index 0 and counter 0.
  - GUARD: dig_sel all inactive and seg blank for GUARD cycles. Then go to SHOW.
  - SHOW: drive the decoded digit for CLK_DIV-GUARD cycles. Then advance the index and go to GUARD.
  - enable=0 in any state: go to IDLE next cycle, and outputs blank on that same edge. Counters clear; blink counter and phase are kept.
- Index wraps from NUM_DIGITS-1 to 0. frame_done pulses on the cycle the last slot's SHOW ends.
- Decoded digit is latched at GUARD entry. A load mid-slot takes effect only at the next slot. Load has 1-cycle capture latency.
- Hex map, seg[6:0]: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=73, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- Leading-zero suppression (lz_suppress=1): a digit is blanked if it and every more-significant digit are 0.
  - Digit 0 is never suppressed; all-zero value shows a single "0".
  - dp still shows on a suppressed digit if dp_in is set.
- Blink: the blink counter increments on frame_done; phase toggles when the count reaches BLINK_DIV-1, then the count clears.
  - In the invisible phase, digits in blink_mask show seg=0 and dp=0, but dig_sel is still driven.
- Suppression and blink are evaluated from the display register at GUARD entry.
- rst mid-slot: immediate blank, return to IDLE; the display register clears.

Decomposition:
- Package t05_ssdisp_pkg holds:
  - the FSM state enum (IDLE, GUARD, SHOW);
  - the 16-entry hex segment constant table;
  - the SEG_BLANK constant.
- One combinational sub-module, t05_ssdec_hex: 4-bit nibble plus blank input in, 7-bit seg out, via the package table.
- Scan FSM, counters, suppression and polarity logic stay in the top module.

Test Plan (NUM_DIGITS=4, CLK_DIV=8, GUARD=2, BLINK_DIV=2, active-high):
- Reset, then enable=1, load value=16'h1234 -> dig_sel 0000 for 2 cycles, then 0001 with seg 4'h4→33 for 6 cycles; then 0010/79, 0100/6D, 1000/30; frame_done pulses once every 32 cycles.
- value=16'h0070, lz_suppress=1 -> digits 3 and 2 seg=00, digit 1 seg=70, digit 0 seg=7E; value=0 -> only digit 0 shows 7E.
- blink_mask=4'b0001, value=16'hABCD -> digit 0 alternates 3D and 00 every 2 frames (64 cycles); other digits are steady.
- load value=16'h0005 during digit-1 SHOW -> digit 1 keeps its old glyph until its slot ends; the new value appears from the next slot.
- enable dropped mid-SHOW -> next cycle dig_sel=0, seg=0, state IDLE; re-enable restarts at digit 0 with GUARD.
- rst asserted mid-frame with SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 -> seg_out=7F, dig_sel=1111 asynchronously; the display register reads 0 after release.
